sa_int_dbuf: RTL and testbench
==============================

Name: sa_int_dbuf

Overview:
Parametrised weight-stationary integer systolic array (ROWS x COLS). It is the successor of the FP32 array with these additions:
- Double-buffered weights: a shadow bank can be loaded while the array streams.
- Internal input skew and output deskew, so callers present and receive whole vectors.
- Valid tracking with an in-flight counter.

It sits between the accelerator's activation/weight streamers and the output writeback.

Parameters:
ROWS, 8, number of PE rows (activation vector length)
COLS, 8, number of PE columns (output vector length)
IN_W, 8, signed activation width
W_W, 8, signed weight width
ACC_W, 32, signed accumulator/output width; elaboration error if ACC_W < IN_W+W_W

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_data[ROWS]  in  IN_W each  unskewed activation vector
in_valid  in  1  in_data holds a real vector
stream_en  in  1  advance the array by one step this cycle
out_data[COLS]  out  ACC_W each  deskewed result vector
out_valid  out  1  one-cycle pulse per result vector
wload_data  in  W_W  shadow weight word
wload_valid  in  1  weight word offered
wload_ready  out  1  shadow bank can accept a word
wswap_req  in  1  level request to copy shadow to active
wswap_ack  out  1  one-cycle pulse; the swap happened at this edge
busy  out  1  in-flight counter nonzero

Behaviour:
- Clock and reset: one clock clk; reset resetn is asynchronous and active-low.
- Reset values: all registers cleared. Active and shadow weights 0, skew/deskew/acc/input pipes 0, out_data 0, out_valid 0, wswap_ack 0, load count 0 (so wload_ready=1), in-flight counter 0 (busy=0).
- Reset mid-operation discards all in-flight data and any partial load.
- Advance: step = stream_en.
  - With stream_en=0, every pipeline register holds.
  - With stream_en=1, all pipelines shift one step.
  - When in_valid=0, zeros are injected and the valid bit is 0.
- Skew and timing:
  - Row r input is delayed r steps.
  - PE(r,c) sees x_r of vector k at step k+r+c.
  - Partial sums are registered between rows; activations are registered between columns.
  - Column c's bottom sum is delayed COLS-1-c further steps, then registered into out_data.
- Latency: the vector accepted at advance step k appears on out_data with out_valid=1 in the cycle after advance step k+ROWS+COLS-2, i.e. ROWS+COLS-1 advancing edges.
  - out_valid = registered (stream_en & valid-chain tip); it is 0 in any cycle following a non-advancing edge.
  - out_data holds its value between results.
- Arithmetic: y_c = sum over r of x_r*W[r][c]. Operands are signed and products are sign-extended to ACC_W. Additions wrap two's-complement modulo 2^ACC_W (default build).
- Weight load (shadow bank):
  - A word is accepted on wload_valid & wload_ready.
  - On acceptance the bank shifts as a delay line: shadow[0][0] <= wload_data; shadow[r][c] <= shadow[r][c-1]; shadow[r][0] <= shadow[r-1][COLS-1].
  - The load count increments on each acceptance. wload_ready = (count != ROWS*COLS).
  - Words are supplied last-first: the first accepted word lands in [ROWS-1][COLS-1].
  - Loading is independent of streaming and may proceed concurrently.
- Swap: accepted on a cycle where all of the following hold: wswap_req=1, count==ROWS*COLS, in-flight==0, and !(stream_en & in_valid).
  - On acceptance: active <= shadow at the edge, count <= 0, and wswap_ack pulses the next cycle.
  - A request is held, with no ack, until all conditions are met. The requester must deassert wswap_req after the ack.
  - No load/swap conflict is possible: swap requires a full bank, which forces wload_ready=0.
- In-flight counter: +1 on an advance with in_valid, -1 on an advance whose valid tip is 1, net on both. Range 0..ROWS+COLS-1. busy = (counter != 0).
- Weights are never mixed within a vector: the active bank changes only when the pipeline is empty.

Optional Feature:
SA_INT_SATURATE_EN
- Defined: every PE addition, including the first row, saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
- Undefined: wrap-around as specified above. Latency and ports are identical in both builds.

Test Plan:
1. Reset: assert resetn=0 mid-stream with 3 vectors in flight → out_valid=0, busy=0, wload_ready=1, out_data all 0; no stale vector emerges after release.
2. ROWS=COLS=4: load W[r][c]=4r+c+1 (16 words, last-first), swap, stream x=[1,2,3,4] then 6 bubble steps → out_valid after the 7th advancing edge, out_data=[90,100,110,120]; wswap_ack pulses once.
3. Stall: same as test 2 but stream_en=0 for 3 cycles after step 2 → identical out_data; out_valid arrives 3 cycles later; no out_valid during the stall.
4. Double buffer: load a new shadow bank (all weights 1) during streaming. Raise wswap_req while 2 vectors are in flight → no ack until busy=0. Next vector [1,2,3,4] → [10,10,10,10]; earlier vectors give the old-weight results.
5. Overflow: ACC_W=16, all x=-128, all W=-128 → out_data=0 in the default build; 32767 with SA_INT_SATURATE_EN.
6. Backpressure: hold wload_valid high → wload_ready falls after the 16th acceptance; the 17th word is not taken and the shadow contents are unchanged.

Source files
------------

// File: rtl/sa_int_dbuf.sv
// sa_int_dbuf: weight-stationary integer systolic array (ROWS x COLS) with a
// double-buffered weight bank, internal input skew / output deskew and an
// in-flight vector counter.
// Optional build macro: SA_INT_SATURATE_EN -- every PE addition saturates to
// the signed ACC_W range instead of wrapping.
module sa_int_dbuf #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic signed [IN_W-1:0]  in_data [ROWS],
  input  logic                    in_valid,
  input  logic                    stream_en,
  output logic signed [ACC_W-1:0] out_data [COLS],
  output logic                    out_valid,
  input  logic signed [W_W-1:0]   wload_data,
  input  logic                    wload_valid,
  output logic                    wload_ready,
  input  logic                    wswap_req,
  output logic                    wswap_ack,
  output logic                    busy
);

  localparam int unsigned NW    = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(NW + 1);
  localparam int unsigned VLEN  = ROWS + COLS - 2;
  localparam int unsigned IF_W  = $clog2(ROWS + COLS);
  localparam int unsigned PW    = IN_W + W_W;
  localparam int unsigned SK_N  = ROWS * (ROWS - 1) / 2;
  localparam int unsigned DS_N  = COLS * (COLS - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NW);

  if (ACC_W < IN_W + W_W) begin : g_acc_w_check
    $error("sa_int_dbuf: ACC_W must be at least IN_W+W_W");
  end
  if (ROWS < 2 || COLS < 2) begin : g_dim_check
    $error("sa_int_dbuf: ROWS and COLS must both be at least 2");
  end

`ifdef SA_INT_SATURATE_EN
  localparam int unsigned AW1 = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Start offset of an n-deep chain inside a packed triangular register file.
  function automatic int unsigned tri_base(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  // Signed product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] pe_mul(input logic signed [IN_W-1:0] x,
                                                     input logic signed [W_W-1:0]  w);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'(w);
    return ACC_W'(p);
  endfunction

  // PE accumulation: wrapping by default, saturating when the macro is set.
  function automatic logic signed [ACC_W-1:0] pe_add(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
`ifdef SA_INT_SATURATE_EN
    logic signed [ACC_W:0] s;
    s = AW1'(a) + AW1'(b);
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Pipeline state
  logic signed [IN_W-1:0]  skew_q     [SK_N];
  logic signed [IN_W-1:0]  skew_d     [SK_N];
  logic signed [IN_W-1:0]  act_q      [ROWS][COLS-1];
  logic signed [IN_W-1:0]  act_d      [ROWS][COLS-1];
  logic signed [ACC_W-1:0] psum_q     [ROWS-1][COLS];
  logic signed [ACC_W-1:0] psum_d     [ROWS-1][COLS];
  logic signed [ACC_W-1:0] dsk_q      [DS_N];
  logic signed [ACC_W-1:0] dsk_d      [DS_N];
  logic signed [ACC_W-1:0] out_data_q [COLS];
  logic signed [ACC_W-1:0] out_data_d [COLS];
  logic [VLEN-1:0]         vld_q, vld_d;
  logic                    out_valid_q, out_valid_d;
  logic [IF_W-1:0]         inflt_q, inflt_d;

  // Weight state
  logic signed [W_W-1:0]   wact_q [NW];
  logic signed [W_W-1:0]   wact_d [NW];
  logic signed [W_W-1:0]   wsh_q  [NW];
  logic signed [W_W-1:0]   wsh_d  [NW];
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic                    wswap_ack_q, wswap_ack_d;

  // Combinational intermediates
  logic signed [IN_W-1:0]  x_eff [ROWS];
  logic signed [IN_W-1:0]  row_x [ROWS];
  logic signed [IN_W-1:0]  xcol  [ROWS][COLS];
  logic signed [ACC_W-1:0] pin   [ROWS][COLS];
  logic signed [ACC_W-1:0] sum   [ROWS][COLS];
  logic signed [ACC_W-1:0] bot   [COLS];
  logic                    load_acc;
  logic                    swap_go;

  // Input gating and per-row skew chains (row r is delayed r steps).
  always_comb begin
    skew_d = skew_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      x_eff[r] = in_valid ? in_data[r] : '0;
    end
    row_x[0] = x_eff[0];
    for (int unsigned r = 1; r < ROWS; r++) begin
      skew_d[tri_base(r)] = x_eff[r];
      for (int unsigned i = 1; i < r; i++) begin
        skew_d[tri_base(r) + i] = skew_q[tri_base(r) + i - 1];
      end
      row_x[r] = skew_q[tri_base(r) + r - 1];
    end
  end

  // PE grid: activations move right, partial sums move down; the bottom row
  // sum is left unregistered so the deskew chain plus out_data register give
  // exactly ROWS+COLS-1 advancing edges of latency.
  always_comb begin
    xcol   = '{default: '0};
    pin    = '{default: '0};
    sum    = '{default: '0};
    bot    = '{default: '0};
    act_d  = act_q;
    psum_d = psum_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      xcol[r][0] = row_x[r];
      for (int unsigned c = 1; c < COLS; c++) begin
        xcol[r][c] = act_q[r][c-1];
      end
    end
    for (int unsigned r = 1; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        pin[r][c] = psum_q[r-1][c];
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        sum[r][c] = pe_add(pin[r][c], pe_mul(xcol[r][c], wact_q[r*COLS + c]));
      end
    end
    for (int unsigned r = 0; r < ROWS - 1; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        psum_d[r][c] = sum[r][c];
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS - 1; c++) begin
        act_d[r][c] = xcol[r][c];
      end
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      bot[c] = sum[ROWS-1][c];
    end
  end

  // Output deskew: column c waits COLS-1-c steps so a whole vector lands together.
  always_comb begin
    dsk_d      = dsk_q;
    out_data_d = '{default: '0};
    out_data_d[COLS-1] = bot[COLS-1];
    for (int unsigned c = 0; c < COLS - 1; c++) begin
      dsk_d[tri_base(COLS-1-c)] = bot[c];
      for (int unsigned i = 1; i < COLS - 1 - c; i++) begin
        dsk_d[tri_base(COLS-1-c) + i] = dsk_q[tri_base(COLS-1-c) + i - 1];
      end
      out_data_d[c] = dsk_q[tri_base(COLS-1-c) + (COLS-1-c) - 1];
    end
  end

  // Valid chain, in-flight count, shadow load and bank swap.
  always_comb begin
    load_acc    = wload_valid & wload_ready;
    swap_go     = wswap_req && (wcnt_q == CNT_FULL) && (inflt_q == '0) &&
                  !(stream_en && in_valid);
    wsh_d       = wsh_q;
    wact_d      = wact_q;
    wcnt_d      = wcnt_q;
    wswap_ack_d = swap_go;
    if (load_acc) begin
      wsh_d[0] = wload_data;
      for (int unsigned i = 1; i < NW; i++) begin
        wsh_d[i] = wsh_q[i-1];
      end
      wcnt_d = wcnt_q + CNT_W'(1);
    end
    if (swap_go) begin
      wact_d = wsh_q;
      wcnt_d = '0;
    end

    vld_d       = {vld_q[VLEN-2:0], in_valid};
    out_valid_d = stream_en & vld_q[VLEN-1];
    inflt_d     = inflt_q;
    case ({stream_en & in_valid, out_valid_d})
      2'b10:   inflt_d = inflt_q + IF_W'(1);
      2'b01:   inflt_d = inflt_q - IF_W'(1);
      default: inflt_d = inflt_q;
    endcase
  end

  // Streaming datapath registers; everything holds when stream_en is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skew_q      <= '{default: '0};
      act_q       <= '{default: '0};
      psum_q      <= '{default: '0};
      dsk_q       <= '{default: '0};
      out_data_q  <= '{default: '0};
      vld_q       <= '0;
      inflt_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (stream_en) begin
        skew_q  <= skew_d;
        act_q   <= act_d;
        psum_q  <= psum_d;
        dsk_q   <= dsk_d;
        vld_q   <= vld_d;
        inflt_q <= inflt_d;
      end
      if (out_valid_d) begin
        out_data_q <= out_data_d;
      end
      out_valid_q <= out_valid_d;
    end
  end

  // Weight banks, load counter and swap acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wsh_q       <= '{default: '0};
      wact_q      <= '{default: '0};
      wcnt_q      <= '0;
      wswap_ack_q <= 1'b0;
    end else begin
      wsh_q       <= wsh_d;
      wact_q      <= wact_d;
      wcnt_q      <= wcnt_d;
      wswap_ack_q <= wswap_ack_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign wload_ready = (wcnt_q != CNT_FULL);
  assign wswap_ack   = wswap_ack_q;
  assign busy        = (inflt_q != '0);

endmodule

// File: tb/tb_sa_int_dbuf.sv
// Scoreboard bench for sa_int_dbuf (4x4, ACC_W=16). Stimulus pushes expected
// result vectors; a negedge monitor pops and compares on every out_valid.
module tb_sa_int_dbuf;

  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned AW = 16;

`ifdef SA_INT_SATURATE_EN
  localparam int OVF_POS = 32767;
  localparam int OVF_NEG = -32768;
`else
  localparam int OVF_POS = 0;
  localparam int OVF_NEG = 512;
`endif

  typedef logic [C-1:0][AW-1:0] ovec_t;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic signed [7:0]    in_data [R];
  logic                 in_valid;
  logic                 stream_en;
  logic signed [AW-1:0] out_data [C];
  logic                 out_valid;
  logic signed [7:0]    wload_data;
  logic                 wload_valid;
  logic                 wload_ready;
  logic                 wswap_req;
  logic                 wswap_ack;
  logic                 busy;

  ovec_t exp_q[$];
  int    sb_applied  = 0;
  int    sb_errors   = 0;
  int    dir_applied = 0;
  int    dir_errors  = 0;

  always #5 clk = ~clk;

  sa_int_dbuf #(.ROWS(R), .COLS(C), .IN_W(8), .W_W(8), .ACC_W(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .stream_en  (stream_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .wload_data (wload_data),
    .wload_valid(wload_valid),
    .wload_ready(wload_ready),
    .wswap_req  (wswap_req),
    .wswap_ack  (wswap_ack),
    .busy       (busy)
  );

  // Monitor: every result vector must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1) begin
      ovec_t e;
      ovec_t g;
      sb_applied++;
      for (int c = 0; c < int'(C); c++) g[c] = out_data[c];
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL unexpected_vector: got out_data=%h, required no out_valid", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          sb_errors++;
          $display("FAIL result_vector: got out_data=%h, required %h", g, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    dir_applied++;
    if (got !== exp) begin
      dir_errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic v, input int x0, input int x1,
                       input int x2, input int x3);
    stream_en  = en;
    in_valid   = v;
    in_data[0] = 8'(x0);
    in_data[1] = 8'(x1);
    in_data[2] = 8'(x2);
    in_data[3] = 8'(x3);
  endtask

  task automatic expect_vec(input int y0, input int y1, input int y2, input int y3);
    ovec_t e;
    e[0] = 16'(y0);
    e[1] = 16'(y1);
    e[2] = 16'(y2);
    e[3] = 16'(y3);
    exp_q.push_back(e);
  endtask

  task automatic load_word(input int w);
    wload_valid = 1'b1;
    wload_data  = 8'(w);
    tick();
    wload_valid = 1'b0;
  endtask

  task automatic bubbles(input int n);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic do_swap();
    int n = 0;
    wswap_req = 1'b1;
    while (wswap_ack !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("swap_ack", wswap_ack, 1);
    wswap_req = 1'b0;
    tick();
    chk("swap_ack_single", wswap_ack, 0);
  endtask

  initial begin
    resetn      = 1'b0;
    wload_valid = 1'b0;
    wload_data  = '0;
    wswap_req   = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (2) tick();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wload_ready", wload_ready, 1);
    chk("rst_wswap_ack", wswap_ack, 0);
    for (int c = 0; c < int'(C); c++) chk("rst_out_data", out_data[c], 0);
    resetn = 1'b1;
    tick();

    // Load W[r][c]=4r+c+1 last-first, swap, single vector with latency check
    for (int i = 0; i < 16; i++) load_word(16 - i);
    chk("wload_ready_full", wload_ready, 0);
    wswap_req = 1'b1;
    tick();
    chk("swap_ack_first", wswap_ack, 1);
    chk("wload_ready_after_swap", wload_ready, 1);
    wswap_req = 1'b0;
    tick();
    chk("swap_ack_one_pulse", wswap_ack, 0);

    expect_vec(90, 100, 110, 120);
    drive(1'b1, 1'b1, 1, 2, 3, 4);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    chk("busy_one_in_flight", busy, 1);
    for (int i = 2; i <= 7; i++) begin
      tick();
      chk("latency_out_valid", out_valid, (i == 7) ? 1 : 0);
    end
    tick();
    chk("out_valid_pulse", out_valid, 0);
    chk("out_data_hold", out_data[0], 90);
    chk("busy_drained", busy, 0);

    // Signed operands
    expect_vec(34, 36, 38, 40);
    drive(1'b1, 1'b1, -1, 2, -3, 4);
    tick();
    bubbles(7);

    // Stall after step 2, and a stall while the valid bit sits at the chain tip
    expect_vec(90, 100, 110, 120);
    drive(1'b1, 1'b1, 1, 2, 3, 4);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_valid", out_valid, 0);
    end
    chk("stall_busy", busy, 1);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 3; i <= 6; i++) begin
      tick();
      chk("post_stall_out_valid", out_valid, 0);
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    chk("tip_stall_out_valid", out_valid, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    tick();
    chk("stalled_vector_out_valid", out_valid, 1);
    tick();

    // Concurrent load of an all-ones bank with backpressure on words 17/18
    for (int i = 0; i < 18; i++) begin
      wload_valid = 1'b1;
      wload_data  = (i < 16) ? 8'sd1 : 8'sd99;
      if (i == 2) begin
        expect_vec(90, 100, 110, 120);
        drive(1'b1, 1'b1, 1, 2, 3, 4);
      end else if (i == 14) begin
        expect_vec(34, 36, 38, 40);
        drive(1'b1, 1'b1, -1, 2, -3, 4);
      end else if (i == 15) begin
        expect_vec(2, 4, 6, 8);
        drive(1'b1, 1'b1, 2, 0, 0, 0);
      end else begin
        drive(1'b1, 1'b0, 0, 0, 0, 0);
      end
      if (i == 15) chk("wload_ready_16th", wload_ready, 1);
      if (i >= 16) chk("wload_ready_backpressure", wload_ready, 0);
      tick();
    end
    wload_valid = 1'b0;
    chk("busy_two_in_flight", busy, 1);
    wswap_req = 1'b1;
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 30) begin
        chk("swap_held_while_busy", wswap_ack, 0);
        tick();
        n++;
      end
    end
    chk("busy_cleared", busy, 0);
    chk("swap_not_same_edge", wswap_ack, 0);
    tick();
    chk("swap_ack_after_drain", wswap_ack, 1);
    wswap_req = 1'b0;
    tick();
    chk("swap_ack_drain_single", wswap_ack, 0);
    chk("wload_ready_reopened", wload_ready, 1);
    expect_vec(10, 10, 10, 10);
    drive(1'b1, 1'b1, 1, 2, 3, 4);
    tick();
    expect_vec(6, 6, 6, 6);
    drive(1'b1, 1'b1, 5, -6, 7, 0);
    tick();
    bubbles(8);

    // Accumulator overflow with an all -128 bank
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) load_word(-128);
    do_swap();
    expect_vec(OVF_POS, OVF_POS, OVF_POS, OVF_POS);
    drive(1'b1, 1'b1, -128, -128, -128, -128);
    tick();
    expect_vec(OVF_NEG, OVF_NEG, OVF_NEG, OVF_NEG);
    drive(1'b1, 1'b1, 127, 127, 127, 127);
    tick();
    bubbles(8);

    // Reset with three vectors in flight and a partial shadow load
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) load_word(3);
    drive(1'b1, 1'b1, 1, 1, 1, 1);
    repeat (3) tick();
    drive(1'b1, 1'b0, 0, 0, 0, 0);
    tick();
    chk("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wload_ready", wload_ready, 1);
    for (int c = 0; c < int'(C); c++) chk("mid_rst_out_data", out_data[c], 0);
    tick();
    resetn = 1'b1;
    bubbles(12);
    chk("post_reset_busy", busy, 0);
    wswap_req = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    wswap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_swap_after_partial_load", wswap_ack, 0);
    end
    wswap_req = 1'b0;
    expect_vec(0, 0, 0, 0);
    drive(1'b1, 1'b1, 1, 2, 3, 4);
    tick();
    bubbles(8);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             sb_applied + dir_applied, sb_errors + dir_errors);
    $finish;
  end

endmodule
